// File: rtl/eth_rgmii_pkg.sv
// Shared RGMII transmit definitions: speed codes, nibble dividers and the
// helpers that map a speed code onto its divider.
package eth_rgmii_pkg;

   typedef enum logic [1:0] {
      SPEED_10M       = 2'b00,
      SPEED_100M      = 2'b01,
      SPEED_1000M     = 2'b10,
      SPEED_1000M_ALT = 2'b11
   } speed_e;

   localparam int unsigned DIV_100M = 5;
   localparam int unsigned DIV_10M  = 50;

   // Both upper codes run at gigabit rate.
   function automatic logic isGigabit(input logic [1:0] spd);
      return spd[1];
   endfunction

   function automatic int unsigned nibbleDivider(input logic [1:0]  spd,
                                                 input int unsigned div10,
                                                 input int unsigned div100);
      if (isGigabit(spd)) begin
         return 1;
      end else if (spd == SPEED_100M) begin
         return div100;
      end else begin
         return div10;
      end
   endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// Nibble-rate divider for the RGMII transmitter: tracks the active speed, the
// position inside the nibble period and produces the forwarded clock pair.
module rgmii_tx_clk_div #(
   parameter int unsigned DIV_100M = eth_rgmii_pkg::DIV_100M,
   parameter int unsigned DIV_10M  = eth_rgmii_pkg::DIV_10M,
   parameter int unsigned CNT_W    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed_i,
   output logic       boundary_o,
   output logic       holdLoad_o,
   output logic       gigNext_o,
   output logic       nibbleStart_o,
   output logic       phaseNext_o,
   output logic       txClkQ1_o,
   output logic       txClkQ2_o
);

   import eth_rgmii_pkg::*;

   localparam int unsigned CW1 = CNT_W + 1;

   logic [1:0]       speed_q, speed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             clkQ1_q, clkQ1_d;
   logic             clkQ2_q, clkQ2_d;

   logic [CW1-1:0]   divCur, divNext, lastCnt;
   logic [CW1-1:0]   slotRise, slotFall;
   logic             gigCur, gigNext, lastCycle, lastHalf, boundary;

   // Speed is only re-sampled at a byte boundary so a nibble is never cut
   // short; the forwarded clock is derived from the next-state count so the
   // registered pair lines up with the count it describes.
   always_comb begin
      gigCur    = isGigabit(speed_q);
      divCur    = CW1'(nibbleDivider(speed_q, DIV_10M, DIV_100M));
      lastCnt   = divCur - CW1'(1);
      lastCycle = ({1'b0, cnt_q} == lastCnt);
      lastHalf  = lastCycle && phase_q && !gigCur;
      boundary  = gigCur || lastHalf;

      speed_d   = boundary ? speed_i : speed_q;
      gigNext   = isGigabit(speed_d);
      divNext   = CW1'(nibbleDivider(speed_d, DIV_10M, DIV_100M));

      cnt_d     = '0;
      phase_d   = 1'b0;
      if (!gigCur) begin
         if (lastCycle) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
         end
      end

      slotRise = {cnt_d, 1'b0};
      slotFall = {cnt_d, 1'b1};
      if (gigNext) begin
         clkQ1_d = 1'b1;
         clkQ2_d = 1'b0;
      end else begin
         clkQ1_d = (slotRise < divNext);
         clkQ2_d = (slotFall < divNext);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_q <= SPEED_1000M;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         clkQ1_q <= 1'b0;
         clkQ2_q <= 1'b0;
      end else begin
         speed_q <= speed_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         clkQ1_q <= clkQ1_d;
         clkQ2_q <= clkQ2_d;
      end
   end

   assign boundary_o    = boundary;
   assign holdLoad_o    = lastHalf;
   assign gigNext_o     = gigNext;
   assign nibbleStart_o = !gigNext && (cnt_d == '0);
   assign phaseNext_o   = phase_d;
   assign txClkQ1_o     = clkQ1_q;
   assign txClkQ2_o     = clkQ2_q;

endmodule

// File: rtl/rgmii_tx_ddr_serializer.sv
// GMII to RGMII transmit serializer: produces registered rising/falling half
// pairs for data, control and forwarded clock at 10/100/1000 Mb/s.
module rgmii_tx_ddr_serializer #(
   parameter int unsigned DIV_100M = eth_rgmii_pkg::DIV_100M,
   parameter int unsigned DIV_10M  = eth_rgmii_pkg::DIV_10M,
   parameter int unsigned CNT_W    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic [7:0] gmii_txd,
   input  logic       gmii_tx_en,
   input  logic       gmii_tx_er,
   output logic       gmii_clk_en,
   output logic [3:0] txd_q1,
   output logic [3:0] txd_q2,
   output logic       tx_ctl_q1,
   output logic       tx_ctl_q2,
   output logic       tx_clk_q1,
   output logic       tx_clk_q2
);

   import eth_rgmii_pkg::*;

   logic       boundary, holdLoad, gigNext, nibbleStart, phaseNext;
   logic [7:0] holdByte_q, holdByte_d;
   logic       holdEn_q, holdEn_d;
   logic       holdEr_q, holdEr_d;
   logic [3:0] txdQ1_q, txdQ1_d;
   logic [3:0] txdQ2_q, txdQ2_d;
   logic       ctlQ1_q, ctlQ1_d;
   logic       ctlQ2_q, ctlQ2_d;
   logic [3:0] nibble;
   logic       nibbleCtl;

   rgmii_tx_clk_div #(
      .DIV_100M (DIV_100M),
      .DIV_10M  (DIV_10M),
      .CNT_W    (CNT_W)
   ) u_clkDiv (
      .clk           (clk),
      .rst           (rst),
      .speed_i       (speed),
      .boundary_o    (boundary),
      .holdLoad_o    (holdLoad),
      .gigNext_o     (gigNext),
      .nibbleStart_o (nibbleStart),
      .phaseNext_o   (phaseNext),
      .txClkQ1_o     (tx_clk_q1),
      .txClkQ2_o     (tx_clk_q2)
   );

   // Gigabit bytes go straight to the output pair; at 10/100 the accepted
   // byte is held and one nibble is presented per period on both halves.
   always_comb begin
      holdByte_d = holdLoad ? gmii_txd   : holdByte_q;
      holdEn_d   = holdLoad ? gmii_tx_en : holdEn_q;
      holdEr_d   = holdLoad ? gmii_tx_er : holdEr_q;

      nibble     = phaseNext ? holdByte_d[7:4] : holdByte_d[3:0];
      nibbleCtl  = holdEn_d ^ (phaseNext & holdEr_d);

      txdQ1_d    = txdQ1_q;
      txdQ2_d    = txdQ2_q;
      ctlQ1_d    = ctlQ1_q;
      ctlQ2_d    = ctlQ2_q;
      if (gigNext) begin
         txdQ1_d = gmii_txd[3:0];
         txdQ2_d = gmii_txd[7:4];
         ctlQ1_d = gmii_tx_en;
         ctlQ2_d = gmii_tx_en ^ gmii_tx_er;
      end else if (nibbleStart) begin
         txdQ1_d = nibble;
         txdQ2_d = nibble;
         ctlQ1_d = nibbleCtl;
         ctlQ2_d = nibbleCtl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdByte_q <= '0;
         holdEn_q   <= 1'b0;
         holdEr_q   <= 1'b0;
         txdQ1_q    <= '0;
         txdQ2_q    <= '0;
         ctlQ1_q    <= 1'b0;
         ctlQ2_q    <= 1'b0;
      end else begin
         holdByte_q <= holdByte_d;
         holdEn_q   <= holdEn_d;
         holdEr_q   <= holdEr_d;
         txdQ1_q    <= txdQ1_d;
         txdQ2_q    <= txdQ2_d;
         ctlQ1_q    <= ctlQ1_d;
         ctlQ2_q    <= ctlQ2_d;
      end
   end

   // The strobe must read 0 for as long as reset is held, even though the
   // divider sits in its gigabit state then.
   assign gmii_clk_en = boundary & ~rst;
   assign txd_q1      = txdQ1_q;
   assign txd_q2      = txdQ2_q;
   assign tx_ctl_q1   = ctlQ1_q;
   assign tx_ctl_q2   = ctlQ2_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_serializer.sv
// Directed bench for the RGMII transmit serializer: gigabit vector table plus
// hand-written 100M, speed-switch, 10M and mid-frame reset sequences.
module tb_rgmii_tx_ddr_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic [7:0] gmiiTxd;
   logic       gmiiTxEn;
   logic       gmiiTxEr;
   logic       gmiiClkEn;
   logic [3:0] txdQ1, txdQ2;
   logic       txCtlQ1, txCtlQ2;
   logic       txClkQ1, txClkQ2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] txd;
      logic       en;
      logic       er;
      logic [3:0] expQ1;
      logic [3:0] expQ2;
      logic       expCtl1;
      logic       expCtl2;
   } gigVector_t;

   gigVector_t gigTable [6];
   logic [1:0] clkPattern100 [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
   logic [7:0] bytes100 [4]      = '{8'h00, 8'h3C, 8'h7E, 8'h00};

   rgmii_tx_ddr_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .speed       (speed),
      .gmii_txd    (gmiiTxd),
      .gmii_tx_en  (gmiiTxEn),
      .gmii_tx_er  (gmiiTxEr),
      .gmii_clk_en (gmiiClkEn),
      .txd_q1      (txdQ1),
      .txd_q2      (txdQ2),
      .tx_ctl_q1   (txCtlQ1),
      .tx_ctl_q2   (txCtlQ2),
      .tx_clk_q1   (txClkQ1),
      .tx_clk_q2   (txClkQ2)
   );

   always #4 clk = ~clk;

   task automatic applyStimulus(input logic [7:0] txd, input logic en, input logic er);
      gmiiTxd  = txd;
      gmiiTxEn = en;
      gmiiTxEr = er;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Expected word layout: {clk_en, txd_q1, txd_q2, ctl_q1, ctl_q2, clk_q1, clk_q2}.
   task automatic checkOutput(input string name, input logic [12:0] expected);
      logic [12:0] actual;
      actual = {gmiiClkEn, txdQ1, txdQ2, txCtlQ1, txCtlQ2, txClkQ1, txClkQ2};
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      int strobeCount;
      int firstStrobe;
      int lastStrobe;
      int highHalves;

      gigTable[0] = '{8'hA5, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1, 1'b1};
      gigTable[1] = '{8'h3C, 1'b1, 1'b1, 4'hC, 4'h3, 1'b1, 1'b0};
      gigTable[2] = '{8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
      gigTable[3] = '{8'hFF, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0};
      gigTable[4] = '{8'h81, 1'b0, 1'b1, 4'h1, 4'h8, 1'b0, 1'b1};
      gigTable[5] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};

      rst   = 1'b1;
      speed = 2'b10;
      applyStimulus(8'h00, 1'b0, 1'b0);
      repeat (3) nextCycle();
      checkOutput("reset state", 13'h0000);

      // Gigabit table; the first vector is presented across reset release.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(gigTable[i].txd, gigTable[i].en, gigTable[i].er);
         if (i == 0) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkOutput("release strobe", {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00});
         end
         nextCycle();
         checkOutput($sformatf("gig vec %0d", i),
                     {1'b1, gigTable[i].expQ1, gigTable[i].expQ2,
                      gigTable[i].expCtl1, gigTable[i].expCtl2, 2'b10});
      end

      // 100M: bytes 0x3C then 0x7E, then idle.
      speed = 2'b01;
      applyStimulus(8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         int         ph;
         int         slot;
         logic [7:0] b;
         logic [3:0] nib;
         logic       e;
         nextCycle();
         ph   = (k / 5) % 2;
         slot = k / 10;
         b    = bytes100[slot];
         e    = (slot == 1) || (slot == 2);
         nib  = (ph == 1) ? b[7:4] : b[3:0];
         checkOutput($sformatf("100M k=%0d", k),
                     {((k % 10) == 9), nib, nib, e, e, clkPattern100[k % 5]});
         if (k < 10) applyStimulus(8'h3C, 1'b1, 1'b0);
         else if (k < 20) applyStimulus(8'h7E, 1'b1, 1'b0);
         else applyStimulus(8'h00, 1'b0, 1'b0);
      end

      // Speed request to 1000M mid-nibble: the 100M byte finishes first.
      for (int k = 0; k < 12; k++) begin
         nextCycle();
         if (k < 10) begin
            checkOutput($sformatf("switch k=%0d", k),
                        {(k == 9), 4'h0, 4'h0, 1'b0, 1'b0, clkPattern100[k % 5]});
         end else if (k == 10) begin
            checkOutput("switch first gig", {1'b1, 4'h2, 4'hD, 1'b1, 1'b1, 2'b10});
         end else begin
            checkOutput("switch second gig", {1'b1, 4'hB, 4'h4, 1'b0, 1'b1, 2'b10});
         end
         if (k == 0) applyStimulus(8'hD2, 1'b1, 1'b0);
         if (k == 2) speed = 2'b10;
         if (k == 10) applyStimulus(8'h4B, 1'b0, 1'b1);
      end

      // 10M: strobe period, clock duty and nibble contents.
      speed       = 2'b00;
      applyStimulus(8'hF3, 1'b1, 1'b0);
      strobeCount = 0;
      firstStrobe = -1;
      lastStrobe  = -1;
      highHalves  = 0;
      for (int k = 0; k < 254; k++) begin
         nextCycle();
         if (gmiiClkEn) begin
            strobeCount++;
            if (firstStrobe < 0) firstStrobe = k;
            lastStrobe = k;
         end
         if (k < 50) highHalves += int'(txClkQ1) + int'(txClkQ2);
         if (k == 24) checkValue("10M clk cnt24", int'({txClkQ1, txClkQ2}), 3);
         if (k == 25) checkValue("10M clk cnt25", int'({txClkQ1, txClkQ2}), 0);
         if (k == 100) checkOutput("10M low nibble", {1'b0, 4'h3, 4'h3, 1'b1, 1'b1, 2'b11});
         if (k == 253) checkOutput("10M high nibble", {1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'b11});
      end
      checkValue("10M strobe count", strobeCount, 2);
      checkValue("10M first strobe", firstStrobe, 99);
      checkValue("10M strobe period", lastStrobe - firstStrobe, 100);
      checkValue("10M clk high halves", highHalves, 50);

      // Mid-frame reset at cnt=3, phase=1 clears outputs without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset", 13'h0000);
      repeat (2) nextCycle();
      checkOutput("reset held", 13'h0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post reset gig strobe", {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00});
      nextCycle();
      checkOutput("post reset cnt0", {1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11});
      nextCycle();
      checkOutput("post reset cnt1", {1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
